group_a_mode1_handshake: RTL and testbench
==========================================

Name: group_a_mode1_handshake

Overview:
Sequencer for Group A port A in 8255-style Mode 1 (strobed I/O). It decodes control-word writes (mode set and BSR), owns the port A data latch, and runs the STB/IBF and OBF/ACK handshakes with INTR generation. It sits between the CPU-side bus interface and the port A pins. It replaces the purely combinational Group A decode when handshake modes are enabled.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the asynchronous stb_n/ack_n pins (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ctrl_wr  in  1  one-cycle strobe: ctrl_word valid
ctrl_word  in  8  control word; bit7=1 is mode set, bit7=0 is BSR
rd_a  in  1  one-cycle CPU read of port A
wr_a  in  1  one-cycle CPU write of port A
cpu_din  in  8  CPU write data
cpu_dout  out  8  port A read data to CPU
pa_in  in  8  port A pins (input direction)
pa_out  out  8  port A output latch
pa_oe  out  1  1 = drive port A pins
stb_n  in  1  async strobe from peripheral (PC4)
ack_n  in  1  async acknowledge from peripheral (PC6)
ibf  out  1  input buffer full (PC5)
obf_n  out  1  output buffer full, active low (PC7)
intr  out  1  interrupt request A (PC3)
inte_a  out  1  interrupt enable flag
mode1  out  1  1 = Mode 1 active
ovr_err  out  1  one-cycle pulse: strobe received while ibf=1

Behaviour:
- Reset (rst_n=0 at clk edge) sets: state M0_IN, mode1=0, pa_oe=0, pa_out=0, cpu_dout=0, ibf=0, obf_n=1, intr=0, inte_a=0, ovr_err=0. Reset mid-handshake aborts it; latched data is cleared.
- Mode set (ctrl_wr, ctrl_word[7]=1):
  - ctrl_word[6:5] selects the mode: 00 = Mode 0, 01 = Mode 1, 1x = treated as Mode 1.
  - ctrl_word[4] selects direction: 1 = input, 0 = output.
  - Effective next cycle. Clears ibf, intr and inte_a, sets obf_n=1, clears pa_out. Next state is M0_IN, M0_OUT, IN_EMPTY or OUT_EMPTY.
- BSR (ctrl_wr, ctrl_word[7]=0): bits[3:1] select the PC bit and bit0 is its value.
  - In input Mode 1, PC4 (100) writes inte_a.
  - In output Mode 1, PC6 (110) writes inte_a.
  - All other BSR writes are ignored here.
  - The new inte_a takes effect next cycle. intr is recomputed as inte_a & (pending condition).
- Synchronizers: stb_n and ack_n each pass through SYNC_STAGES flops, then an edge detector.
  - A pin edge produces a one-cycle internal fall/rise pulse SYNC_STAGES+1 cycles later.
- M0_IN: pa_oe=0; cpu_dout <= pa_in every cycle; handshake outputs held inactive.
- M0_OUT: pa_oe=1; wr_a loads pa_out <= cpu_din next cycle.
- IN_EMPTY: pa_oe=0.
  - On stb fall: latch <= pa_in, cpu_dout <= pa_in, ibf <= 1, go to IN_FULL.
- IN_FULL:
  - On stb rise: intr <= inte_a.
  - On rd_a: ibf <= 0, intr <= 0, go to IN_EMPTY next cycle; cpu_dout holds its value.
  - On stb fall while in IN_FULL: latch unchanged, ovr_err pulses 1 cycle.
  - Simultaneous rd_a and stb fall: rd_a is processed first; the new data is latched and the state stays IN_FULL (ibf stays 1).
- OUT_EMPTY: pa_oe=1, obf_n=1.
  - On wr_a: pa_out <= cpu_din, obf_n <= 0, intr <= 0, go to OUT_FULL.
- OUT_FULL:
  - On ack fall: obf_n <= 1.
  - On ack rise: intr <= inte_a, go to OUT_EMPTY.
  - wr_a in OUT_FULL overwrites pa_out, keeps obf_n=0 and clears intr.
  - Simultaneous wr_a and ack fall: the write wins and obf_n stays 0.
- Priority within a cycle: reset > ctrl_wr > rd_a/wr_a > synchronized pin edges.
- rd_a in output modes and wr_a in input modes are ignored.

Decomposition:
- Package ppi_pkg holds:
  - control-word field positions (MODE_FLAG=7, GA_MODE=6:5, PA_DIR=4, BSR_SEL=3:1, BSR_VAL=0);
  - mode codes;
  - PC bit indices (PC_INTE_IN=4, PC_INTE_OUT=6);
  - the state enum {M0_IN, M0_OUT, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL}.
- Sub-module edge_sync (parameter SYNC_STAGES; outputs fall/rise pulses) is instantiated twice, once for stb_n and once for ack_n.

Test Plan:
1. Reset, then ctrl_word=8'hB0 (Mode 1 input), then BSR 8'h09 (PC4=1) -> mode1=1, pa_oe=0, inte_a=1, ibf=0, intr=0.
2. Input handshake: pa_in=8'h5A, pulse stb_n low 4 cycles -> ibf=1 exactly 3 cycles after the fall, cpu_dout=8'h5A, intr=1 after the stb rise. Then rd_a -> ibf=0, intr=0 next cycle.
3. Overrun: with ibf=1, pa_in=8'hC3, second stb pulse -> ovr_err pulses once, cpu_dout stays 8'h5A.
4. Output: ctrl_word=8'hA0, BSR 8'h0D; wr_a with cpu_din=8'h96 -> pa_out=8'h96, obf_n=0. ack_n pulse -> obf_n=1 after the synced fall, intr=1 after the rise.
5. Simultaneous wr_a and synced ack fall in OUT_FULL -> obf_n stays 0 and pa_out takes the new data. BSR 8'h0C -> inte_a=0, and the next ack produces no intr.
6. Mode 0 (ctrl_word=8'h90) with pa_in changing 8'h11 to 8'h22 -> cpu_dout follows with 1 cycle delay, ibf=0, obf_n=1. rst_n low during IN_FULL -> all outputs return to reset values.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255-style Group A port A sequencer:
// control-word field positions, mode codes, PC bit indices and FSM states.
package ppi_pkg;

    localparam int MODE_FLAG  = 7;
    localparam int GA_MODE_HI = 6;
    localparam int GA_MODE_LO = 5;
    localparam int PA_DIR     = 4;
    localparam int BSR_SEL_HI = 3;
    localparam int BSR_SEL_LO = 1;
    localparam int BSR_VAL    = 0;

    localparam logic [1:0] GA_MODE0 = 2'b00;
    localparam logic [1:0] GA_MODE1 = 2'b01;

    localparam logic [2:0] PC_INTE_IN  = 3'd4;
    localparam logic [2:0] PC_INTE_OUT = 3'd6;

    typedef enum logic [2:0] {
        M0_IN     = 3'd0,
        M0_OUT    = 3'd1,
        IN_EMPTY  = 3'd2,
        IN_FULL   = 3'd3,
        OUT_EMPTY = 3'd4,
        OUT_FULL  = 3'd5
    } pa_state_t;

    // Modes 1x are handled as Mode 1, so anything other than 00 is strobed.
    function automatic pa_state_t mode_set_state(input logic [7:0] word);
        logic strobed;
        strobed = (word[GA_MODE_HI:GA_MODE_LO] != GA_MODE0);
        if (word[PA_DIR])
            return strobed ? IN_EMPTY : M0_IN;
        else
            return strobed ? OUT_EMPTY : M0_OUT;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous active-low pin followed by an
// edge detector producing one-cycle fall/rise pulses.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Pins idle high, so the chain resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg[0] <= 1'b1;
        end else begin
            sync_reg[0] <= din;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign fall = prev_reg & ~sync_reg[SYNC_STAGES-1];
    assign rise = ~prev_reg & sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/group_a_mode1_handshake.sv
// Group A port A sequencer: control-word decode, port A data latch and the
// Mode 1 STB/IBF and OBF/ACK handshakes with INTR generation.
module group_a_mode1_handshake
    import ppi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_wr,
    input  logic [7:0] ctrl_word,
    input  logic       rd_a,
    input  logic       wr_a,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    input  logic       stb_n,
    input  logic       ack_n,
    output logic       ibf,
    output logic       obf_n,
    output logic       intr,
    output logic       inte_a,
    output logic       mode1,
    output logic       ovr_err
);

    pa_state_t state_reg;
    logic      pend_reg;
    logic      stb_fall, stb_rise, ack_fall, ack_rise;
    logic      bsr_hits_inte;
    logic [2:0] bsr_sel;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (stb_n),
        .fall  (stb_fall),
        .rise  (stb_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ack_n),
        .fall  (ack_fall),
        .rise  (ack_rise)
    );

    assign bsr_sel = ctrl_word[BSR_SEL_HI:BSR_SEL_LO];

    // Only the INTE bit belonging to the active Mode 1 direction is owned here.
    always_comb begin
        bsr_hits_inte = 1'b0;
        case (state_reg)
            IN_EMPTY, IN_FULL:   bsr_hits_inte = (bsr_sel == PC_INTE_IN);
            OUT_EMPTY, OUT_FULL: bsr_hits_inte = (bsr_sel == PC_INTE_OUT);
            default:             bsr_hits_inte = 1'b0;
        endcase
    end

    // pend_reg remembers that the interrupt condition is met, so that a later
    // INTE change can re-evaluate intr without another peripheral edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= M0_IN;
            pend_reg  <= 1'b0;
            mode1     <= 1'b0;
            pa_oe     <= 1'b0;
            pa_out    <= 8'h00;
            cpu_dout  <= 8'h00;
            ibf       <= 1'b0;
            obf_n     <= 1'b1;
            intr      <= 1'b0;
            inte_a    <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            if (ctrl_wr) begin
                if (ctrl_word[MODE_FLAG]) begin
                    state_reg <= mode_set_state(ctrl_word);
                    mode1     <= (ctrl_word[GA_MODE_HI:GA_MODE_LO] != GA_MODE0);
                    pa_oe     <= ~ctrl_word[PA_DIR];
                    pa_out    <= 8'h00;
                    ibf       <= 1'b0;
                    obf_n     <= 1'b1;
                    intr      <= 1'b0;
                    inte_a    <= 1'b0;
                    pend_reg  <= 1'b0;
                end else if (bsr_hits_inte) begin
                    inte_a <= ctrl_word[BSR_VAL];
                    intr   <= ctrl_word[BSR_VAL] & pend_reg;
                end
            end else begin
                case (state_reg)
                    M0_IN: begin
                        cpu_dout <= pa_in;
                    end
                    M0_OUT: begin
                        if (wr_a) pa_out <= cpu_din;
                    end
                    IN_EMPTY: begin
                        if (stb_fall) begin
                            cpu_dout  <= pa_in;
                            ibf       <= 1'b1;
                            state_reg <= IN_FULL;
                        end
                    end
                    IN_FULL: begin
                        if (rd_a) begin
                            intr     <= 1'b0;
                            pend_reg <= 1'b0;
                            // A strobe landing on the read refills the buffer at once.
                            if (stb_fall) begin
                                cpu_dout <= pa_in;
                            end else begin
                                ibf       <= 1'b0;
                                state_reg <= IN_EMPTY;
                            end
                        end else begin
                            if (stb_fall) ovr_err <= 1'b1;
                            if (stb_rise) begin
                                pend_reg <= 1'b1;
                                intr     <= inte_a;
                            end
                        end
                    end
                    OUT_EMPTY: begin
                        if (wr_a) begin
                            pa_out    <= cpu_din;
                            obf_n     <= 1'b0;
                            intr      <= 1'b0;
                            pend_reg  <= 1'b0;
                            state_reg <= OUT_FULL;
                        end
                    end
                    OUT_FULL: begin
                        if (wr_a) begin
                            pa_out   <= cpu_din;
                            obf_n    <= 1'b0;
                            intr     <= 1'b0;
                            pend_reg <= 1'b0;
                        end else if (ack_rise) begin
                            obf_n     <= 1'b1;
                            pend_reg  <= 1'b1;
                            intr      <= inte_a;
                            state_reg <= OUT_EMPTY;
                        end else if (ack_fall) begin
                            obf_n <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= M0_IN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_group_a_mode1_handshake.sv
// Directed bench for the Group A port A Mode 1 sequencer; each task drives one
// scenario and compares outputs against hand-computed values.
module tb_group_a_mode1_handshake;

    logic       clk;
    logic       rst_n;
    logic       ctrl_wr;
    logic [7:0] ctrl_word;
    logic       rd_a;
    logic       wr_a;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic       stb_n;
    logic       ack_n;
    logic       ibf;
    logic       obf_n;
    logic       intr;
    logic       inte_a;
    logic       mode1;
    logic       ovr_err;

    int vectors;
    int miscompares;

    group_a_mode1_handshake #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_wr   (ctrl_wr),
        .ctrl_word (ctrl_word),
        .rd_a      (rd_a),
        .wr_a      (wr_a),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .pa_in     (pa_in),
        .pa_out    (pa_out),
        .pa_oe     (pa_oe),
        .stb_n     (stb_n),
        .ack_n     (ack_n),
        .ibf       (ibf),
        .obf_n     (obf_n),
        .intr      (intr),
        .inte_a    (inte_a),
        .mode1     (mode1),
        .ovr_err   (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge; all drives and samples happen here.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ctrl_write(input logic [7:0] w);
        ctrl_wr   = 1'b1;
        ctrl_word = w;
        tick();
        ctrl_wr   = 1'b0;
        ctrl_word = 8'h00;
    endtask

    task automatic cpu_write(input logic [7:0] d);
        wr_a    = 1'b1;
        cpu_din = d;
        tick();
        wr_a    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        vectors++;
        if ({mode1, pa_oe, ibf, obf_n, intr, inte_a, ovr_err} !== 7'b0001000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0001000",
                     {mode1, pa_oe, ibf, obf_n, intr, inte_a, ovr_err});
        end
        vectors++;
        if ({pa_out, cpu_dout} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: got pa_out=%h cpu_dout=%h want 00 00", pa_out, cpu_dout);
        end
        $display("test_reset: mode1=%b obf_n=%b pa_out=%h", mode1, obf_n, pa_out);
    endtask

    task automatic test_mode1_input_setup;
        ctrl_write(8'hB0);
        ctrl_write(8'h09);
        vectors++;
        if ({mode1, pa_oe, inte_a, ibf, intr} !== 5'b10100) begin
            miscompares++;
            $display("FAIL in_setup: got mode1,pa_oe,inte_a,ibf,intr=%b want 10100",
                     {mode1, pa_oe, inte_a, ibf, intr});
        end
        $display("test_mode1_input_setup: mode1=%b inte_a=%b", mode1, inte_a);
    endtask

    task automatic test_input_handshake;
        pa_in = 8'h5A;
        stb_n = 1'b0;
        tick(2);
        vectors++;
        if (ibf !== 1'b0) begin
            miscompares++;
            $display("FAIL ibf_early: got %b want 0 two cycles after strobe", ibf);
        end
        tick();
        vectors++;
        if (ibf !== 1'b1 || cpu_dout !== 8'h5A) begin
            miscompares++;
            $display("FAIL ibf_latch: got ibf=%b cpu_dout=%h want 1 5a", ibf, cpu_dout);
        end
        tick();
        stb_n = 1'b1;
        tick(2);
        vectors++;
        if (intr !== 1'b0) begin
            miscompares++;
            $display("FAIL intr_early: got %b want 0", intr);
        end
        tick();
        vectors++;
        if (intr !== 1'b1) begin
            miscompares++;
            $display("FAIL intr_stb_rise: got %b want 1", intr);
        end
        $display("test_input_handshake: ibf=%b cpu_dout=%h intr=%b", ibf, cpu_dout, intr);
    endtask

    task automatic test_overrun;
        int pulses;
        pulses = 0;
        pa_in = 8'hC3;
        stb_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ovr_err === 1'b1) pulses++;
            if (i == 2) begin
                vectors++;
                if (ovr_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovr_timing: got ovr_err=%b want 1 at third cycle", ovr_err);
                end
            end
        end
        stb_n = 1'b1;
        tick(4);
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL ovr_count: got %0d pulses want 1", pulses);
        end
        vectors++;
        if (cpu_dout !== 8'h5A || ibf !== 1'b1 || intr !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_hold: got cpu_dout=%h ibf=%b intr=%b want 5a 1 1", cpu_dout, ibf, intr);
        end
        rd_a = 1'b1;
        tick();
        rd_a = 1'b0;
        vectors++;
        if (ibf !== 1'b0 || intr !== 1'b0 || cpu_dout !== 8'h5A) begin
            miscompares++;
            $display("FAIL read_clear: got ibf=%b intr=%b cpu_dout=%h want 0 0 5a", ibf, intr, cpu_dout);
        end
        $display("test_overrun: pulses=%0d cpu_dout=%h", pulses, cpu_dout);
    endtask

    task automatic test_output_handshake;
        ctrl_write(8'hA0);
        vectors++;
        if ({mode1, pa_oe, obf_n, inte_a} !== 4'b1110) begin
            miscompares++;
            $display("FAIL out_setup: got mode1,pa_oe,obf_n,inte_a=%b want 1110",
                     {mode1, pa_oe, obf_n, inte_a});
        end
        ctrl_write(8'h0D);
        cpu_write(8'h96);
        vectors++;
        if (pa_out !== 8'h96 || obf_n !== 1'b0 || inte_a !== 1'b1) begin
            miscompares++;
            $display("FAIL out_write: got pa_out=%h obf_n=%b inte_a=%b want 96 0 1", pa_out, obf_n, inte_a);
        end
        ack_n = 1'b0;
        tick(2);
        vectors++;
        if (obf_n !== 1'b0) begin
            miscompares++;
            $display("FAIL obf_early: got %b want 0", obf_n);
        end
        tick();
        vectors++;
        if (obf_n !== 1'b1 || intr !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_fall: got obf_n=%b intr=%b want 1 0", obf_n, intr);
        end
        ack_n = 1'b1;
        tick(3);
        vectors++;
        if (intr !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_rise_intr: got %b want 1", intr);
        end
        $display("test_output_handshake: pa_out=%h obf_n=%b intr=%b", pa_out, obf_n, intr);
    endtask

    task automatic test_back_to_back;
        cpu_write(8'h33);
        vectors++;
        if (intr !== 1'b0 || obf_n !== 1'b0) begin
            miscompares++;
            $display("FAIL refill: got intr=%b obf_n=%b want 0 0", intr, obf_n);
        end
        ack_n = 1'b0;
        tick(2);
        wr_a    = 1'b1;
        cpu_din = 8'h77;
        tick();
        wr_a    = 1'b0;
        vectors++;
        if (obf_n !== 1'b0 || pa_out !== 8'h77) begin
            miscompares++;
            $display("FAIL wr_vs_ack: got obf_n=%b pa_out=%h want 0 77", obf_n, pa_out);
        end
        tick(2);
        ack_n = 1'b1;
        tick(3);
        vectors++;
        if (intr !== 1'b1 || obf_n !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_rise: got intr=%b obf_n=%b want 1 1", intr, obf_n);
        end
        ctrl_write(8'h0C);
        vectors++;
        if (inte_a !== 1'b0 || intr !== 1'b0) begin
            miscompares++;
            $display("FAIL inte_off: got inte_a=%b intr=%b want 0 0", inte_a, intr);
        end
        cpu_write(8'h44);
        ack_n = 1'b0;
        tick(4);
        ack_n = 1'b1;
        tick(4);
        vectors++;
        if (intr !== 1'b0 || obf_n !== 1'b1 || pa_out !== 8'h44) begin
            miscompares++;
            $display("FAIL masked_ack: got intr=%b obf_n=%b pa_out=%h want 0 1 44", intr, obf_n, pa_out);
        end
        $display("test_back_to_back: pa_out=%h inte_a=%b intr=%b", pa_out, inte_a, intr);
    endtask

    task automatic test_mode0_and_reset;
        ctrl_write(8'h90);
        pa_in = 8'h11;
        tick();
        vectors++;
        if (cpu_dout !== 8'h11 || mode1 !== 1'b0 || pa_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL m0_first: got cpu_dout=%h mode1=%b pa_oe=%b want 11 0 0", cpu_dout, mode1, pa_oe);
        end
        pa_in = 8'h22;
        #1;
        vectors++;
        if (cpu_dout !== 8'h11) begin
            miscompares++;
            $display("FAIL m0_delay: got %h want 11 before the edge", cpu_dout);
        end
        tick();
        vectors++;
        if (cpu_dout !== 8'h22 || ibf !== 1'b0 || obf_n !== 1'b1) begin
            miscompares++;
            $display("FAIL m0_follow: got cpu_dout=%h ibf=%b obf_n=%b want 22 0 1", cpu_dout, ibf, obf_n);
        end
        ctrl_write(8'hB0);
        ctrl_write(8'h09);
        pa_in = 8'hE7;
        stb_n = 1'b0;
        tick(4);
        stb_n = 1'b1;
        tick(4);
        vectors++;
        if (ibf !== 1'b1 || cpu_dout !== 8'hE7 || intr !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_full: got ibf=%b cpu_dout=%h intr=%b want 1 e7 1", ibf, cpu_dout, intr);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({mode1, pa_oe, ibf, obf_n, intr, inte_a, ovr_err} !== 7'b0001000 ||
            pa_out !== 8'h00 || cpu_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: got flags=%b pa_out=%h cpu_dout=%h want 0001000 00 00",
                     {mode1, pa_oe, ibf, obf_n, intr, inte_a, ovr_err}, pa_out, cpu_dout);
        end
        $display("test_mode0_and_reset: cpu_dout=%h ibf=%b", cpu_dout, ibf);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        ctrl_wr   = 1'b0;
        ctrl_word = 8'h00;
        rd_a      = 1'b0;
        wr_a      = 1'b0;
        cpu_din   = 8'h00;
        pa_in     = 8'h00;
        stb_n     = 1'b1;
        ack_n     = 1'b1;

        test_reset();
        test_mode1_input_setup();
        test_input_handshake();
        test_overrun();
        test_output_handshake();
        test_back_to_back();
        test_mode0_and_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
